keccak_round_sequencer: RTL and testbench

Sequential counterpart to the table-based round-constant lookup. It drives the round sequence of a masked Keccak-f[25W] permutation core and produces the round number and the iota round constant on the fly. The constant comes from the Keccak rc LFSR, not from a ROM. It sits between the permutation datapath and the top-level control FSM, and replaces both the external round counter and the RC table.

---
 rtl/keccak_pkg.sv | 52 +++++
 rtl/keccak_round_sequencer_if.sv | 24 ++
 rtl/keccak_rc_lfsr.sv | 44 ++++
 rtl/keccak_round_sequencer.sv | 127 ++++++++++++
 tb/tb_keccak_round_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak round sequencer: lane-width helpers,
// the rc LFSR step functions and the sequencer state encoding.
package keccak_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [7:0] RC_FEEDBACK = 8'h71;
  localparam logic [7:0] RC_INIT     = 8'h01;

  function automatic int unsigned lane_log2(input int unsigned w);
    case (w)
      32'd8:   return 32'd3;
      32'd16:  return 32'd4;
      32'd32:  return 32'd5;
      32'd64:  return 32'd6;
      default: return 32'd3;
    endcase
  endfunction

  function automatic int unsigned num_rounds(input int unsigned w);
    return 32'd12 + 32'd2 * lane_log2(w);
  endfunction

  // One step of x^8+x^6+x^5+x^4+1: shift left, fold the dropped MSB back in.
  function automatic logic [7:0] rc_step(input logic [7:0] s);
    logic [7:0] sh;
    sh = {s[6:0], 1'b0};
    if (s[7]) begin
      return sh ^ RC_FEEDBACK;
    end else begin
      return sh;
    end
  endfunction

  function automatic logic [7:0] rc_step7(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int i = 32'sd0; i < 32'sd7; i++) begin
      t = rc_step(t);
    end
    return t;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/keccak_round_sequencer_if.sv
// Control/status bundle between the top-level FSM (master) and the
// round sequencer (slave).
interface keccak_round_sequencer_if #(
  parameter int unsigned W = 32'd8
);
  logic         StartxSI;
  logic         BusyxSO;
  logic [4:0]   RoundNrxDO;
  logic [1:0]   PhasexDO;
  logic [W-1:0] RCxDO;
  logic         StateWExSO;
  logic         LastRoundxSO;
  logic         DonexSO;

  modport master (
    output StartxSI,
    input  BusyxSO, RoundNrxDO, PhasexDO, RCxDO, StateWExSO, LastRoundxSO, DonexSO
  );

  modport slave (
    input  StartxSI,
    output BusyxSO, RoundNrxDO, PhasexDO, RCxDO, StateWExSO, LastRoundxSO, DonexSO
  );
endinterface

// File: rtl/keccak_rc_lfsr.sv
// Keccak rc LFSR: 8-bit state with init/advance-by-7 controls and the
// L+1 rc bits of the current round derived combinationally.
module keccak_rc_lfsr
  import keccak_pkg::*;
#(
  parameter int unsigned LB = 32'd3
) (
  input  logic        ClkxCI,
  input  logic        RstxRI,
  input  logic        init_s,
  input  logic        adv_s,
  output logic [LB:0] rc_bits_s
);

  logic [7:0]  lfsr_r;
  logic [7:0]  walk_s;
  logic [LB:0] bits_s;

  // LFSR state register: one round's worth of steps per advance
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      lfsr_r <= RC_INIT;
    end else if (init_s) begin
      lfsr_r <= RC_INIT;
    end else if (adv_s) begin
      lfsr_r <= rc_step7(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Bit j is taken after j steps; shifting in at the MSB leaves j=0 at bit 0.
  always_comb begin
    walk_s = lfsr_r;
    bits_s = '0;
    for (int j = 32'sd0; j <= $signed(LB); j++) begin
      bits_s = {walk_s[0], bits_s[LB:1]};
      walk_s = rc_step(walk_s);
    end
  end

  assign rc_bits_s = bits_s;

endmodule

// File: rtl/keccak_round_sequencer.sv
// Round sequencer for a masked Keccak-f[25W] core: round/phase counters,
// state-write strobe and the on-the-fly iota round constant.
module keccak_round_sequencer
  import keccak_pkg::*;
#(
  parameter int unsigned W   = 32'd8,
  parameter int unsigned CPR = 32'd2
) (
  input  logic                     ClkxCI,
  input  logic                     RstxRI,
  keccak_round_sequencer_if.slave  bus
);

  localparam int unsigned L       = lane_log2(W);
  localparam int unsigned ROUNDS  = num_rounds(W);
  localparam logic [1:0]  PH_LAST = 2'(CPR - 32'd1);
  localparam logic [4:0]  RN_LAST = 5'(ROUNDS - 32'd1);

  seq_state_e   state_r;
  logic [4:0]   round_r;
  logic [1:0]   phase_r;
  logic         busy_r;
  logic         we_r;
  logic         last_r;
  logic         done_r;
  logic         last_phase_s;
  logic         last_round_s;
  logic         lfsr_init_s;
  logic         lfsr_adv_s;
  logic [L:0]   rc_bits_s;
  logic [W-1:0] rc_s;

  assign last_phase_s = (phase_r == PH_LAST);
  assign last_round_s = (round_r == RN_LAST);
  assign lfsr_init_s  = (state_r == ST_IDLE) |
                        ((state_r == ST_RUN) & last_phase_s & last_round_s);
  assign lfsr_adv_s   = (state_r == ST_RUN) & last_phase_s & ~last_round_s;

  keccak_rc_lfsr #(.LB(L)) u_rc_lfsr (
    .ClkxCI    (ClkxCI),
    .RstxRI    (RstxRI),
    .init_s    (lfsr_init_s),
    .adv_s     (lfsr_adv_s),
    .rc_bits_s (rc_bits_s)
  );

  // Sequencer FSM with counters and registered status outputs
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_r <= ST_IDLE;
      round_r <= 5'd0;
      phase_r <= 2'd0;
      busy_r  <= 1'b0;
      we_r    <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          round_r <= 5'd0;
          phase_r <= 2'd0;
          done_r  <= 1'b0;
          last_r  <= 1'b0;
          if (bus.StartxSI) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            we_r    <= (CPR == 32'd1);
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_phase_s && last_round_s) begin
            state_r <= ST_DONE;
            round_r <= 5'd0;
            phase_r <= 2'd0;
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (last_phase_s) begin
            round_r <= round_r + 5'd1;
            phase_r <= 2'd0;
            we_r    <= (CPR == 32'd1);
            last_r  <= (round_r + 5'd1 == RN_LAST);
          end else begin
            phase_r <= phase_r + 2'd1;
            we_r    <= (phase_r + 2'd1 == PH_LAST);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          round_r <= 5'd0;
          phase_r <= 2'd0;
          busy_r  <= 1'b0;
          we_r    <= 1'b0;
          last_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // rc bit j lands on lane bit 2^j-1; every other lane bit is constant zero.
  for (genvar b = 0; b < W; b++) begin : g_rc
    if (is_pow2(b + 1)) begin : g_on
      assign rc_s[b] = busy_r & rc_bits_s[$clog2(b + 1)];
    end else begin : g_off
      assign rc_s[b] = 1'b0;
    end
  end

  assign bus.BusyxSO      = busy_r;
  assign bus.RoundNrxDO   = round_r;
  assign bus.PhasexDO     = phase_r;
  assign bus.RCxDO        = rc_s;
  assign bus.StateWExSO   = we_r;
  assign bus.LastRoundxSO = last_r;
  assign bus.DonexSO      = done_r;

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Directed bench for keccak_round_sequencer: W=8/CPR=2 and W=64/CPR=1
// instances checked against hand-computed Keccak round constants.
module tb_keccak_round_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt;
  int   busy_cnt;

  always #5 clk = ~clk;

  keccak_round_sequencer_if #(.W(8))  b8  ();
  keccak_round_sequencer_if #(.W(64)) b64 ();

  keccak_round_sequencer #(.W(8), .CPR(2)) dut8 (
    .ClkxCI (clk),
    .RstxRI (rst),
    .bus    (b8)
  );

  keccak_round_sequencer #(.W(64), .CPR(1)) dut64 (
    .ClkxCI (clk),
    .RstxRI (rst),
    .bus    (b64)
  );

  logic [7:0] rc8_tab [0:17] = '{8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01,
                                 8'h81, 8'h09, 8'h8A, 8'h88, 8'h09, 8'h0A,
                                 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string tag, input logic busy, input int rnd, input int ph,
                         input logic [7:0] rc, input logic we, input logic last, input logic done);
    check_eq({tag, ".busy"},  64'(b8.BusyxSO),      64'(busy));
    check_eq({tag, ".round"}, 64'(b8.RoundNrxDO),   64'(rnd));
    check_eq({tag, ".phase"}, 64'(b8.PhasexDO),     64'(ph));
    check_eq({tag, ".rc"},    64'(b8.RCxDO),        64'(rc));
    check_eq({tag, ".we"},    64'(b8.StateWExSO),   64'(we));
    check_eq({tag, ".last"},  64'(b8.LastRoundxSO), 64'(last));
    check_eq({tag, ".done"},  64'(b8.DonexSO),      64'(done));
  endtask

  // idx counts RUN cycles from 0; two cycles per round at CPR=2
  task automatic expect8_run(input string tag, input int idx);
    expect8(tag, 1'b1, idx / 2, idx % 2, rc8_tab[idx / 2], (idx % 2) == 1, (idx / 2) == 17, 1'b0);
  endtask

  task automatic expect8_idle(input string tag, input logic done);
    expect8(tag, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0, done);
  endtask

  task automatic idle_all(input string tag);
    check_eq({tag, ".w8"}, 64'({b8.BusyxSO, b8.RoundNrxDO, b8.PhasexDO, b8.RCxDO,
                                b8.StateWExSO, b8.LastRoundxSO, b8.DonexSO}), 64'd0);
    check_eq({tag, ".w64rc"}, b64.RCxDO, 64'd0);
    check_eq({tag, ".w64ctl"}, 64'({b64.BusyxSO, b64.RoundNrxDO, b64.PhasexDO,
                                    b64.StateWExSO, b64.LastRoundxSO, b64.DonexSO}), 64'd0);
  endtask

  // Full nominal W=8 run from a one-cycle Start pulse
  task automatic run8(input string tag);
    b8.StartxSI = 1'b1;
    tick();
    b8.StartxSI = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      expect8_run(tag, i);
      if (b8.StateWExSO === 1'b1) we_cnt++;
      tick();
    end
    expect8_idle({tag, ".done"}, 1'b1);
    check_eq({tag, ".we_pulses"}, 64'(we_cnt), 64'd18);
    tick();
    expect8_idle({tag, ".after"}, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    b8.StartxSI  = 1'b1;
    b64.StartxSI = 1'b1;
    repeat (3) tick();
    idle_all("reset_hold");
    b8.StartxSI  = 1'b0;
    b64.StartxSI = 1'b0;
    rst = 1'b0;
    tick();
    idle_all("reset_rel");

    for (int i = 0; i < 100; i++) begin
      idle_all("idle");
      tick();
    end

    run8("nom");

    // W=64, CPR=1: write enable every cycle, phase stuck at 0
    b64.StartxSI = 1'b1;
    tick();
    b64.StartxSI = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 24; n++) begin
      check_eq("w64.round", 64'(b64.RoundNrxDO), 64'(n));
      check_eq("w64.phase", 64'(b64.PhasexDO), 64'd0);
      check_eq("w64.we", 64'(b64.StateWExSO), 64'd1);
      check_eq("w64.last", 64'(b64.LastRoundxSO), 64'(n == 23));
      check_eq("w64.done", 64'(b64.DonexSO), 64'd0);
      if (n == 0)  check_eq("w64.rc0",  b64.RCxDO, 64'h0000000000000001);
      if (n == 1)  check_eq("w64.rc1",  b64.RCxDO, 64'h0000000000008082);
      if (n == 23) check_eq("w64.rc23", b64.RCxDO, 64'h8000000080008008);
      if (b64.BusyxSO === 1'b1) busy_cnt++;
      tick();
    end
    check_eq("w64.done_pulse", 64'(b64.DonexSO), 64'd1);
    check_eq("w64.busy_end", 64'(b64.BusyxSO), 64'd0);
    check_eq("w64.rc_end", b64.RCxDO, 64'd0);
    check_eq("w64.busy_cycles", 64'(busy_cnt), 64'd24);
    tick();
    idle_all("w64.after");

    // Start held for 50 edges: one run, Done, one IDLE cycle, second run
    b8.StartxSI = 1'b1;
    tick();
    for (int n = 1; n <= 80; n++) begin
      if (n <= 36)                  expect8_run("hold", n - 1);
      else if (n == 37 || n == 75)  expect8_idle("hold.done", 1'b1);
      else if (n >= 39 && n <= 74)  expect8_run("hold2", n - 39);
      else                          expect8_idle("hold.idle", 1'b0);
      b8.StartxSI = (n < 50);
      tick();
    end

    // Reset at round 7 phase 1 aborts without a Done pulse
    b8.StartxSI = 1'b1;
    tick();
    b8.StartxSI = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect8_run("abort", i);
      tick();
    end
    expect8_run("abort.r7p1", 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect8_idle("abort.rst", 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_eq("abort.no_done", 64'({b8.DonexSO, b8.BusyxSO}), 64'd0);
    end
    run8("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
